ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  execute stage holds a valid instruction.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 alu_result  input  32  ALU Result: memory address, writeback value or compare result.
REQ-007 alu_zero  input  1  ALU Zero flag.
REQ-008 rs2_data  input  32  store data.
REQ-009 branch_target_in  input  32  precomputed PC+imm or jump target.
REQ-010 rd  input  5; funct3  input  3.
REQ-011 ctrl_branch, ctrl_jump, ctrl_memread, ctrl_memwrite, ctrl_regwrite  input  1 each  decoded controls.
REQ-012 flush  input  1  kill the held and incoming instruction.
REQ-013 out_ready  input  1  memory stage accepts.
REQ-014 out_valid  output  1; out_alu_result  output  32; out_store_data  output  32; out_rd  output  5; out_funct3  output  3.
REQ-015 out_memread, out_memwrite, out_regwrite  output  1 each.
REQ-016 branch_taken  output  1  redirect pulse; branch_target  output  32  redirect address.
REQ-017 out_misalign  output  1  registered misaligned-access flag.

Function
REQ-018 Single-entry register; in_ready SHALL equal (!out_valid || out_ready) && !reset.
REQ-019 Accept = in_valid && in_ready && !flush; on accept all out_* SHALL load from inputs at the next edge and out_valid SHALL become 1.
REQ-020 When out_valid && out_ready && !accept, out_valid SHALL clear at the next edge.
REQ-021 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-022 Simultaneous drain and accept SHALL replace the entry with no bubble (out_valid stays 1).
REQ-023 flush=1 SHALL clear out_valid at the next edge and block capture, regardless of in_valid/out_ready.
REQ-024 Branch condition by funct3: 000 alu_zero; 001 !alu_zero; 100/110 alu_result[0]; 101/111 !alu_result[0]; 010/011 not taken.
REQ-025 branch_taken SHALL be 1 for exactly one cycle after an accepted instruction with ctrl_jump=1, or ctrl_branch=1 and condition true; 0 otherwise.
REQ-026 branch_target SHALL register branch_target_in on accept and hold otherwise.
REQ-027 Branch/jump instructions SHALL still propagate to out_valid (jump link uses out_regwrite).
REQ-028 Latency: input to outputs exactly 1 cycle; no combinational path from alu_result to any output.

Reset
REQ-029 Reset SHALL have priority over flush and accept.
REQ-030 At the edge with reset=1 all registered outputs SHALL be 0 (out_valid, branch_taken, out_misalign, data, controls); in_ready SHALL be 0 while reset is high and 1 the cycle after.
REQ-031 Reset mid-stall SHALL discard the held entry; no branch_taken pulse after reset.

Configuration
REQ-032 Macro EX_MEM_MISALIGN_CHECK_EN SHALL enable alignment checking on accepted memread/memwrite.
REQ-033 Defined: funct3[1:0]=10 requires alu_result[1:0]=00, 01 requires alu_result[0]=0; on violation out_misalign=1 and out_memread, out_memwrite, out_regwrite forced 0 for that entry.
REQ-034 Undefined: out_misalign tied 0; controls pass unchanged; no check logic present.

Verification
REQ-035 Reset, then in_valid=1, alu_result=0x00000010, ctrl_regwrite=1, rd=5, out_ready=1 -> next cycle out_valid=1, out_alu_result=0x10, out_rd=5, out_regwrite=1.
REQ-036 BNE funct3=001, alu_zero=0, ctrl_branch=1, branch_target_in=0x00000100 -> branch_taken=1 one cycle, branch_target=0x100; alu_zero=1 -> branch_taken=0.
REQ-037 out_ready=0 for 3 cycles with entry held, in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> new entry loads next edge, out_valid stays 1.
REQ-038 flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, branch_taken=0.
REQ-039 EN defined: ctrl_memwrite=1, funct3=010, alu_result=0x00000006 -> out_misalign=1, out_memwrite=0; undefined -> out_misalign=0, out_memwrite=1.
REQ-040 reset=1 during held stall -> next cycle out_valid=0, all outputs 0, in_ready=0; reset=0 -> in_ready=1.

Source files
------------

// File: rtl/ex_mem_if.sv
// ex_mem_if: execute-to-memory pipeline register bus.
// master = execute side (drives the instruction and out_ready),
// slave  = the ex_mem_stage register itself.
interface ex_mem_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] rs2_data;
  logic [31:0] branch_target_in;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        ctrl_branch;
  logic        ctrl_jump;
  logic        ctrl_memread;
  logic        ctrl_memwrite;
  logic        ctrl_regwrite;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_memread;
  logic        out_memwrite;
  logic        out_regwrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_misalign;

  modport master (
    output in_valid, alu_result, alu_zero, rs2_data, branch_target_in, rd, funct3,
           ctrl_branch, ctrl_jump, ctrl_memread, ctrl_memwrite, ctrl_regwrite,
           flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_rd, out_funct3,
           out_memread, out_memwrite, out_regwrite, branch_taken, branch_target,
           out_misalign
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, rs2_data, branch_target_in, rd, funct3,
           ctrl_branch, ctrl_jump, ctrl_memread, ctrl_memwrite, ctrl_regwrite,
           flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_rd, out_funct3,
           out_memread, out_memwrite, out_regwrite, branch_taken, branch_target,
           out_misalign
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: single-entry EX/MEM pipeline register with valid/ready
// handshake, branch resolution (one-cycle redirect pulse) and flush.
// Optional build macro EX_MEM_MISALIGN_CHECK_EN adds an alignment check on
// loads/stores; a misaligned entry raises out_misalign and has its
// memread/memwrite/regwrite suppressed. Without the macro out_misalign is 0.
module ex_mem_stage (
  input logic     clk,
  input logic     reset,
  ex_mem_if.slave bus
);

  logic        out_valid_q;
  logic [31:0] alu_result_q;
  logic [31:0] store_data_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic        memread_q;
  logic        memwrite_q;
  logic        regwrite_q;
  logic        branch_taken_q;
  logic [31:0] branch_target_q;

  logic accept;
  logic cond_true;
  logic taken_d;
  logic misalign_d;
  logic memread_d;
  logic memwrite_d;
  logic regwrite_d;

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !reset;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Branch condition selected by funct3 (BEQ/BNE use zero, compares use bit 0).
  always_comb begin
    cond_true = 1'b0;
    case (bus.funct3)
      3'b000:          cond_true = bus.alu_zero;
      3'b001:          cond_true = !bus.alu_zero;
      3'b100, 3'b110:  cond_true = bus.alu_result[0];
      3'b101, 3'b111:  cond_true = !bus.alu_result[0];
      default:         cond_true = 1'b0;
    endcase
    taken_d = bus.ctrl_jump || (bus.ctrl_branch && cond_true);
  end

`ifdef EX_MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  always_comb begin
    misalign_d = 1'b0;
    if (bus.ctrl_memread || bus.ctrl_memwrite) begin
      if (bus.funct3[1:0] == 2'b10)
        misalign_d = (bus.alu_result[1:0] != 2'b00);
      else if (bus.funct3[1:0] == 2'b01)
        misalign_d = bus.alu_result[0];
    end
    memread_d  = bus.ctrl_memread  && !misalign_d;
    memwrite_d = bus.ctrl_memwrite && !misalign_d;
    regwrite_d = bus.ctrl_regwrite && !misalign_d;
  end

  // Misalign flag travels with the entry it belongs to.
  always_ff @(posedge clk) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (accept)
      misalign_q <= misalign_d;
  end

  assign bus.out_misalign = misalign_q;
`else
  // Controls pass straight through; no alignment check in this build.
  always_comb begin
    misalign_d = 1'b0;
    memread_d  = bus.ctrl_memread;
    memwrite_d = bus.ctrl_memwrite;
    regwrite_d = bus.ctrl_regwrite;
  end

  assign bus.out_misalign = 1'b0;
`endif

  // Entry register: reset beats flush beats accept; drain clears valid only.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      alu_result_q    <= 32'd0;
      store_data_q    <= 32'd0;
      rd_q            <= 5'd0;
      funct3_q        <= 3'd0;
      memread_q       <= 1'b0;
      memwrite_q      <= 1'b0;
      regwrite_q      <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= 32'd0;
    end else begin
      branch_taken_q <= accept && taken_d;
      if (accept) begin
        out_valid_q     <= 1'b1;
        alu_result_q    <= bus.alu_result;
        store_data_q    <= bus.rs2_data;
        rd_q            <= bus.rd;
        funct3_q        <= bus.funct3;
        memread_q       <= memread_d;
        memwrite_q      <= memwrite_d;
        regwrite_q      <= regwrite_d;
        branch_target_q <= bus.branch_target_in;
      end else if (bus.flush || bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_alu_result = alu_result_q;
  assign bus.out_store_data = store_data_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_funct3     = funct3_q;
  assign bus.out_memread    = memread_q;
  assign bus.out_memwrite   = memwrite_q;
  assign bus.out_regwrite   = regwrite_q;
  assign bus.branch_taken   = branch_taken_q;
  assign bus.branch_target  = branch_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table followed by randomized traffic
// checked against a cycle-level behavioural model of the stage.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_mem_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef EX_MEM_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif
  localparam logic MW_EXP = !MIS_EN;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, iv, ordy, fl;
    logic [31:0] alu;
    logic        z;
    logic [2:0]  f3;
    logic        br, jp, mr, mw, rw;
    logic [4:0]  rd;
    logic [31:0] bt;
    logic        e_ir, e_ov;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_rw, e_mw, e_tk;
    logic [31:0] e_bt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[15];

  typedef struct {
    logic        v;
    logic [31:0] alu, sd, bt;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, rw, tk, mis;
  } mstate_t;

  mstate_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] alu, input logic z, input logic [31:0] rs2,
                       input logic [2:0] f3, input logic br, input logic jp,
                       input logic mr, input logic mw, input logic rw,
                       input logic [4:0] rd, input logic [31:0] bt);
    reset                = rst;
    bus.in_valid         = iv;
    bus.out_ready        = ordy;
    bus.flush            = fl;
    bus.alu_result       = alu;
    bus.alu_zero         = z;
    bus.rs2_data         = rs2;
    bus.funct3           = f3;
    bus.ctrl_branch      = br;
    bus.ctrl_jump        = jp;
    bus.ctrl_memread     = mr;
    bus.ctrl_memwrite    = mw;
    bus.ctrl_regwrite    = rw;
    bus.rd               = rd;
    bus.branch_target_in = bt;
  endtask

  function automatic logic ref_cond(input logic [2:0] f3, input logic z, input logic [31:0] alu);
    logic lsb;
    lsb = alu[0];
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4 || f3 == 3'd6) return lsb;
    if (f3 == 3'd5 || f3 == 3'd7) return !lsb;
    return 1'b0;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] alu);
    int unsigned sz;
    logic [1:0] low;
    low = f3[1:0];
    sz = (low == 2'd2) ? 4 : (low == 2'd1) ? 2 : 1;
    return (alu % sz) != 0;
  endfunction

  initial begin
    vecs[0]  = '{1,0,0,0, 32'h0,0,3'd0, 0,0,0,0,0, 5'd0,32'h0,   0, 0,32'h0, 5'd0,0,0,0,32'h0,  0};
    vecs[1]  = '{0,1,1,0, 32'h10,0,3'd0, 0,0,0,0,1, 5'd5,32'h0,  1, 1,32'h10,5'd5,1,0,0,32'h0,  0};
    vecs[2]  = '{0,1,1,0, 32'h20,0,3'd1, 1,0,0,0,0, 5'd0,32'h100,1, 1,32'h20,5'd0,0,0,1,32'h100,0};
    vecs[3]  = '{0,1,1,0, 32'h30,1,3'd1, 1,0,0,0,0, 5'd1,32'h200,1, 1,32'h30,5'd1,0,0,0,32'h200,0};
    vecs[4]  = '{0,0,1,0, 32'h0,0,3'd0, 0,0,0,0,0, 5'd0,32'h0,   1, 0,32'h30,5'd1,0,0,0,32'h200,0};
    vecs[5]  = '{0,1,0,0, 32'h40,0,3'd0, 0,0,0,0,1, 5'd2,32'h44, 1, 1,32'h40,5'd2,1,0,0,32'h44, 0};
    vecs[6]  = '{0,1,0,0, 32'h50,0,3'd0, 0,1,0,0,1, 5'd3,32'h54, 0, 1,32'h40,5'd2,1,0,0,32'h44, 0};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{0,1,1,0, 32'h50,0,3'd0, 0,1,0,0,1, 5'd3,32'h54, 1, 1,32'h50,5'd3,1,0,1,32'h54, 0};
    vecs[10] = '{0,1,1,1, 32'h60,0,3'd0, 0,1,0,0,1, 5'd4,32'h64, 1, 0,32'h50,5'd3,1,0,0,32'h54, 0};
    vecs[11] = '{0,1,0,0, 32'h6,0,3'd2,  0,0,0,1,0, 5'd6,32'h0,  1, 1,32'h6, 5'd6,0,MW_EXP,0,32'h0,MIS_EN};
    vecs[12] = '{0,1,0,0, 32'h70,0,3'd0, 0,0,0,0,1, 5'd7,32'h74, 0, 1,32'h6, 5'd6,0,MW_EXP,0,32'h0,MIS_EN};
    vecs[13] = '{1,1,0,0, 32'h70,0,3'd0, 0,0,0,0,1, 5'd7,32'h74, 0, 0,32'h0, 5'd0,0,0,0,32'h0,  0};
    vecs[14] = '{0,0,1,0, 32'h0,0,3'd0, 0,0,0,0,0, 5'd0,32'h0,   1, 0,32'h0, 5'd0,0,0,0,32'h0,  0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].alu, vecs[i].z,
            ~vecs[i].alu, vecs[i].f3, vecs[i].br, vecs[i].jp, vecs[i].mr, vecs[i].mw,
            vecs[i].rw, vecs[i].rd, vecs[i].bt);
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d out_alu_result", i), bus.out_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d out_rd", i), {27'd0, bus.out_rd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d out_regwrite", i), {31'd0, bus.out_regwrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d out_memwrite", i), {31'd0, bus.out_memwrite}, {31'd0, vecs[i].e_mw});
      chk($sformatf("v%0d branch_taken", i), {31'd0, bus.branch_taken}, {31'd0, vecs[i].e_tk});
      chk($sformatf("v%0d branch_target", i), bus.branch_target, vecs[i].e_bt);
      chk($sformatf("v%0d out_misalign", i), {31'd0, bus.out_misalign}, {31'd0, vecs[i].e_mis});
    end

    // Randomized traffic; the first cycle is a reset so the model starts in step.
    m = '{v: 1'b0, alu: 32'd0, sd: 32'd0, bt: 32'd0, rd: 5'd0, f3: 3'd0,
          mr: 1'b0, mw: 1'b0, rw: 1'b0, tk: 1'b0, mis: 1'b0};
    for (int c = 0; c < 2000; c++) begin
      logic rst, iv, ordy, fl, z, br, jp, mr, mw, rw, exp_ir, acc, bad_al;
      logic [31:0] alu, rs2, bt;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [109:0] act_v, exp_v;
      rst  = (c == 0) || ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 9) == 0);
      alu  = $urandom;
      z    = $urandom_range(0, 1);
      rs2  = $urandom;
      bt   = $urandom;
      f3   = 3'($urandom_range(0, 7));
      br   = $urandom_range(0, 1);
      jp   = ($urandom_range(0, 3) == 0);
      mr   = $urandom_range(0, 1);
      mw   = $urandom_range(0, 1);
      rw   = $urandom_range(0, 1);
      rd   = 5'($urandom_range(0, 31));
      drive(rst, iv, ordy, fl, alu, z, rs2, f3, br, jp, mr, mw, rw, rd, bt);
      exp_ir = !rst && (!m.v || ordy);
      #1;
      chk($sformatf("r%0d in_ready", c), {31'd0, bus.in_ready}, {31'd0, exp_ir});

      acc = iv && exp_ir && !fl;
      if (rst) begin
        m = '{v: 1'b0, alu: 32'd0, sd: 32'd0, bt: 32'd0, rd: 5'd0, f3: 3'd0,
              mr: 1'b0, mw: 1'b0, rw: 1'b0, tk: 1'b0, mis: 1'b0};
      end else if (acc) begin
        bad_al = MIS_EN && (mr || mw) && ref_misaligned(f3, alu);
        m.v   = 1'b1;
        m.alu = alu;
        m.sd  = rs2;
        m.bt  = bt;
        m.rd  = rd;
        m.f3  = f3;
        m.mr  = mr && !bad_al;
        m.mw  = mw && !bad_al;
        m.rw  = rw && !bad_al;
        m.mis = bad_al;
        m.tk  = jp || (br && ref_cond(f3, z, alu));
      end else begin
        if (fl || ordy) m.v = 1'b0;
        m.tk = 1'b0;
      end

      @(posedge clk);
      #1;
      act_v = {bus.out_valid, bus.out_alu_result, bus.out_store_data, bus.out_rd,
               bus.out_funct3, bus.out_memread, bus.out_memwrite, bus.out_regwrite,
               bus.branch_taken, bus.branch_target, bus.out_misalign};
      exp_v = {m.v, m.alu, m.sd, m.rd, m.f3, m.mr, m.mw, m.rw, m.tk, m.bt, m.mis};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL r%0d outputs: got %h expected %h", c, act_v, exp_v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
